// File: rtl/rr_reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package rr_reg_write_arbiter_pkg;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

  // (base + off) mod n, for base < n and off < n
  function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_reg_write_arbiter_if.sv
// Requester-side bus of the arbiter: requests, data, acknowledges and register view.
interface rr_reg_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       ack;
  logic                   wr_en;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   busy;
  logic [WIDTH-1:0]       q;

  modport master (output req, wdata, input ack, wr_en, gnt_idx, busy, q);
  modport slave  (input req, wdata, output ack, wr_en, gnt_idx, busy, q);
endinterface

// File: rtl/rr_reg_write_arbiter_dff.sv
// Single-bit storage cell with synchronous reset and write enable.
module rr_dff_cell (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= 1'b0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/rr_reg_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after rr_ptr, wrapping.
module rr_pick
  import rr_reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);
  logic [IDX_W-1:0] cand_idx [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'(rr_wrap(32'(rr_ptr), gi, N_REQ));
    end
  endgenerate

  // Scan from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        valid  = 1'b1;
        winner = cand_idx[k];
      end
    end
  end
endmodule

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin write arbiter: ARB picks and latches a winner, COMMIT writes the shared register.
module rr_reg_write_arbiter
  import rr_reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  rr_reg_write_arbiter_if.slave  bus
);
  localparam int IDX_W = idx_width(N_REQ);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] rr_ptr_reg, gnt_idx_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] q_bits;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             wr_en;
  logic             busy;
  logic             in_commit;
  logic [WIDTH-1:0] wdata_slot [N_REQ];

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_reg),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign wdata_slot[gi] = bus.wdata[gi*WIDTH +: WIDTH];
      assign bus.ack[gi]    = in_commit && (gnt_idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_ARB;
      rr_ptr_reg  <= '0;
      gnt_idx_reg <= '0;
      data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_ARB && pick_valid) begin
        gnt_idx_reg <= pick_idx;
        data_reg    <= wdata_slot[pick_idx];
      end
      // The winner just served drops to lowest priority.
      if (state_reg == ST_COMMIT)
        rr_ptr_reg <= IDX_W'(rr_wrap(32'(gnt_idx_reg), 1, N_REQ));
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ARB:    if (pick_valid) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_ARB;
      default:   state_next = ST_ARB;
    endcase
  end

  always_comb begin
    in_commit = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    if (state_reg == ST_COMMIT) begin
      in_commit = 1'b1;
      wr_en     = 1'b1;
      busy      = 1'b1;
    end
  end

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      rr_dff_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .en    (wr_en),
        .d     (data_reg[gi]),
        .q     (q_bits[gi])
      );
    end
  endgenerate

  assign bus.wr_en   = wr_en;
  assign bus.busy    = busy;
  assign bus.gnt_idx = gnt_idx_reg;
  assign bus.q       = q_bits;
endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Self-checking bench: vector table plus directed sequences, with a write scoreboard.
module tb_rr_reg_write_arbiter;
  logic clk;
  logic reset;
  int checks = 0;
  int errors = 0;

  rr_reg_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  rr_reg_write_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_gnt;
    logic [7:0]  exp_q;
  } vec_t;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];
  logic       pend = 1'b0;
  logic [7:0] pend_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every write seen on the bus must match the head of the scoreboard.
  always @(negedge clk) begin
    if (pend) begin
      chk("sb_q", {24'h0, bus.q}, {24'h0, pend_q});
      pend = 1'b0;
    end
    if (!reset && bus.wr_en) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", {30'h0, bus.gnt_idx}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("write: gnt=%0d ack=%b data=%02h", bus.gnt_idx, bus.ack, e.data);
        chk("sb_gnt", {30'h0, bus.gnt_idx}, {30'h0, e.idx});
        chk("sb_ack", {28'h0, bus.ack}, 32'h1 << e.idx);
        pend   = 1'b1;
        pend_q = e.data;
      end
    end
  end

  initial begin
    vecs[0] = '{4'b0100, 32'h11_A5_22_33, 4'b0100, 2'd2, 8'hA5};
    vecs[1] = '{4'b0001, 32'h99_88_77_3C, 4'b0001, 2'd0, 8'h3C};
    vecs[2] = '{4'b1000, 32'hC3_01_02_03, 4'b1000, 2'd3, 8'hC3};
    vecs[3] = '{4'b0010, 32'h00_00_5F_00, 4'b0010, 2'd1, 8'h5F};
    vecs[4] = '{4'b1011, 32'hD4_00_B2_A1, 4'b1000, 2'd3, 8'hD4};
    vecs[5] = '{4'b0110, 32'h00_E7_6B_00, 4'b0010, 2'd1, 8'h6B};

    reset     = 1'b1;
    bus.req   = 4'b1111;
    bus.wdata = 32'hFF_EE_DD_CC;

    // Reset held with all requests active.
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_q", {24'h0, bus.q}, 32'h0);
      chk("rst_ack", {28'h0, bus.ack}, 32'h0);
      chk("rst_wr_en", {31'h0, bus.wr_en}, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_gnt", {30'h0, bus.gnt_idx}, 32'h0);
    end
    reset   = 1'b0;
    bus.req = 4'b0000;
    step();

    // Table: request held in ARB, dropped during the ack cycle.
    for (int i = 0; i < 6; i++) begin
      bus.req   = vecs[i].req;
      bus.wdata = vecs[i].wdata;
      push(vecs[i].exp_gnt, vecs[i].exp_q);
      step();
      chk($sformatf("v%0d_ack", i), {28'h0, bus.ack}, {28'h0, vecs[i].exp_ack});
      chk($sformatf("v%0d_wr_en", i), {31'h0, bus.wr_en}, 32'h1);
      chk($sformatf("v%0d_busy", i), {31'h0, bus.busy}, 32'h1);
      chk($sformatf("v%0d_gnt", i), {30'h0, bus.gnt_idx}, {30'h0, vecs[i].exp_gnt});
      bus.req = 4'b0000;
      step();
      chk($sformatf("v%0d_q", i), {24'h0, bus.q}, {24'h0, vecs[i].exp_q});
      chk($sformatf("v%0d_ack_off", i), {28'h0, bus.ack}, 32'h0);
    end

    // Reset between transactions returns q and the pointer to zero.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_q", {24'h0, bus.q}, 32'h0);

    // Full contention from rr_ptr=0; each winner drops on its ack.
    bus.req   = 4'b1111;
    bus.wdata = 32'h44_33_22_11;
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd2, 8'h33); push(2'd3, 8'h44);
    for (int w = 0; w < 4; w++) begin
      logic [7:0] exp_q;
      step();
      chk($sformatf("cont%0d_gnt", w), {30'h0, bus.gnt_idx}, w);
      chk($sformatf("cont%0d_ack", w), {28'h0, bus.ack}, 32'h1 << w);
      bus.req[w] = 1'b0;
      step();
      exp_q = 8'h11 * 8'(w + 1);
      chk($sformatf("cont%0d_q", w), {24'h0, bus.q}, {24'h0, exp_q});
    end

    // Idle: register holds.
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_wr_en", {31'h0, bus.wr_en}, 32'h0);
      chk("idle_q", {24'h0, bus.q}, 32'h44);
    end

    // Late drop: req0 gone and data changed right after the ARB edge.
    bus.req   = 4'b0001;
    bus.wdata = 32'h00_00_00_77;
    push(2'd0, 8'h77);
    step();
    bus.req   = 4'b0000;
    bus.wdata = 32'h00_00_00_FF;
    chk("late_ack", {28'h0, bus.ack}, 32'h1);
    chk("late_wr_en", {31'h0, bus.wr_en}, 32'h1);
    step();
    chk("late_q", {24'h0, bus.q}, 32'h77);
    chk("late_ack_off", {28'h0, bus.ack}, 32'h0);
    step();
    chk("late_ack_once", {28'h0, bus.ack}, 32'h0);

    // Fairness/wrap: write by 1, then req0 and req3 held continuously.
    bus.req   = 4'b0010;
    bus.wdata = 32'h00_00_21_00;
    push(2'd1, 8'h21);
    step();
    chk("fair_first_gnt", {30'h0, bus.gnt_idx}, 32'h1);
    bus.req   = 4'b1001;
    bus.wdata = 32'hB3_00_00_B0;
    push(2'd3, 8'hB3); push(2'd0, 8'hB0); push(2'd3, 8'hB3); push(2'd0, 8'hB0);
    step();
    for (int w = 0; w < 4; w++) begin
      logic [1:0] exp_g;
      logic [7:0] exp_d;
      exp_g = (w % 2 == 0) ? 2'd3 : 2'd0;
      exp_d = (w % 2 == 0) ? 8'hB3 : 8'hB0;
      step();
      chk($sformatf("fair%0d_gnt", w), {30'h0, bus.gnt_idx}, {30'h0, exp_g});
      if (w == 3) bus.req = 4'b0000;
      step();
      chk($sformatf("fair%0d_q", w), {24'h0, bus.q}, {24'h0, exp_d});
    end

    // Reset on the edge closing COMMIT discards the write.
    bus.req   = 4'b0100;
    bus.wdata = 32'h00_5A_00_00;
    step();
    chk("rstc_in_commit", {31'h0, bus.wr_en}, 32'h1);
    reset   = 1'b1;
    bus.req = 4'b0000;
    step();
    reset = 1'b0;
    chk("rstc_q", {24'h0, bus.q}, 32'h0);
    chk("rstc_ack", {28'h0, bus.ack}, 32'h0);
    chk("rstc_wr_en", {31'h0, bus.wr_en}, 32'h0);
    chk("rstc_busy", {31'h0, bus.busy}, 32'h0);
    step();
    chk("rstc_no_write", {24'h0, bus.q}, 32'h0);

    // Pointer back at 0: full contention picks requester 0.
    bus.req   = 4'b1111;
    bus.wdata = 32'h04_03_02_01;
    push(2'd0, 8'h01);
    step();
    bus.req = 4'b0000;
    chk("rstc_ptr_gnt", {30'h0, bus.gnt_idx}, 32'h0);
    step();
    step();

    chk("sb_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
